// File: rtl/algo_1r2wg_rd_tracker.sv
// Read-response tracker for the 1r2wg memory: credit-gated issue, in-order tag/address pairing,
// buffered responses with valid/ready, and ECC error statistics with a first-error log.
module algo_1r2wg_rd_tracker #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BITADDR = 13,
  parameter int unsigned BITPADR = 15,
  parameter int unsigned BITTAG  = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned BITDPTH = 3,
  parameter int unsigned CNTWDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [BITADDR-1:0] req_adr,
  input  logic [BITTAG-1:0]  req_tag,
  output logic               read,
  output logic [BITADDR-1:0] rd_adr,
  input  logic               rd_vld,
  input  logic [WIDTH-1:0]   rd_dout,
  input  logic               rd_serr,
  input  logic               rd_derr,
  input  logic [BITPADR-1:0] rd_padr,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [BITTAG-1:0]  rsp_tag,
  output logic [WIDTH-1:0]   rsp_dout,
  output logic               rsp_serr,
  output logic               rsp_derr,
  input  logic               err_clr,
  output logic [CNTWDTH-1:0] serr_cnt,
  output logic [CNTWDTH-1:0] derr_cnt,
  output logic               err_vld,
  output logic               err_dbl,
  output logic [BITADDR-1:0] err_adr,
  output logic [BITPADR-1:0] err_padr,
  output logic               unexp
);

  localparam int unsigned CW = BITDPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [BITDPTH-1:0] PTR_ONE = BITDPTH'(1);
  localparam logic [CNTWDTH-1:0] ERR_MAX = '1;
  localparam logic [CNTWDTH-1:0] ERR_ONE = CNTWDTH'(1);

  typedef struct packed {
    logic [BITTAG-1:0]  tag;
    logic [BITADDR-1:0] adr;
  } tq_ent_t;

  typedef struct packed {
    logic [BITTAG-1:0] tag;
    logic [WIDTH-1:0]  dout;
    logic              serr;
    logic              derr;
  } rs_ent_t;

  logic [CW-1:0]      crd;
  logic               pop;
  logic               match;
  logic               tq_empty;
  logic               rs_empty;
  logic               cnt_serr;
  logic               cnt_derr;
  logic               err_evt;

  tq_ent_t            tq_mem [DEPTH];
  logic [BITDPTH-1:0] tq_wptr;
  logic [BITDPTH-1:0] tq_rptr;
  logic [CW-1:0]      tq_cnt;
  tq_ent_t            tq_head;

  rs_ent_t            rs_mem [DEPTH];
  logic [BITDPTH-1:0] rs_wptr;
  logic [BITDPTH-1:0] rs_rptr;
  logic [CW-1:0]      rs_cnt;
  rs_ent_t            rs_head;

  // Issue path: combinational accept and pass-through to the macro read port.
  assign req_rdy = ready & (crd != '0);
  assign read    = req_vld & req_rdy;
  assign rd_adr  = req_adr;
  assign pop     = rsp_vld & rsp_rdy;

  assign tq_empty = (tq_cnt == '0);
  assign rs_empty = (rs_cnt == '0);
  assign match    = rd_vld & ~tq_empty;
  assign tq_head  = tq_mem[tq_rptr];
  assign rs_head  = rs_mem[rs_rptr];

  // A credit is held from issue until the host pops the matching response.
  always_ff @(posedge clk) begin
    if (rst) begin
      crd <= DEPTH_C;
    end else if (read & ~pop) begin
      crd <= crd - CNT_ONE;
    end else if (pop & ~read) begin
      crd <= crd + CNT_ONE;
    end
  end

  // Tag FIFO holds {tag, adr} of every read still waiting for its macro return.
  always_ff @(posedge clk) begin
    if (rst) begin
      tq_wptr <= '0;
      tq_rptr <= '0;
      tq_cnt  <= '0;
    end else begin
      if (read) begin
        tq_wptr <= tq_wptr + PTR_ONE;
      end
      if (match) begin
        tq_rptr <= tq_rptr + PTR_ONE;
      end
      case ({read, match})
        2'b10:   tq_cnt <= tq_cnt + CNT_ONE;
        2'b01:   tq_cnt <= tq_cnt - CNT_ONE;
        default: tq_cnt <= tq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (read) begin
      tq_mem[tq_wptr] <= '{tag: req_tag, adr: req_adr};
    end
  end

  // Response FIFO: registered write, no fall-through; head is stable until popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_wptr <= '0;
      rs_rptr <= '0;
      rs_cnt  <= '0;
    end else begin
      if (match) begin
        rs_wptr <= rs_wptr + PTR_ONE;
      end
      if (pop) begin
        rs_rptr <= rs_rptr + PTR_ONE;
      end
      case ({match, pop})
        2'b10:   rs_cnt <= rs_cnt + CNT_ONE;
        2'b01:   rs_cnt <= rs_cnt - CNT_ONE;
        default: rs_cnt <= rs_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (match) begin
      rs_mem[rs_wptr] <= '{tag: tq_head.tag, dout: rd_dout, serr: rd_serr, derr: rd_derr};
    end
  end

  assign rsp_vld  = ~rs_empty;
  assign rsp_tag  = rs_empty ? '0 : rs_head.tag;
  assign rsp_dout = rs_empty ? '0 : rs_head.dout;
  assign rsp_serr = rs_empty ? 1'b0 : rs_head.serr;
  assign rsp_derr = rs_empty ? 1'b0 : rs_head.derr;

  // A double-bit error dominates: a return flagged both ways counts only as derr.
  assign cnt_derr = match & rd_derr;
  assign cnt_serr = match & rd_serr & ~rd_derr;
  assign err_evt  = cnt_serr | cnt_derr;

  // Saturating counters; an error arriving with err_clr restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      serr_cnt <= '0;
    end else if (err_clr) begin
      serr_cnt <= cnt_serr ? ERR_ONE : '0;
    end else if (cnt_serr && (serr_cnt != ERR_MAX)) begin
      serr_cnt <= serr_cnt + ERR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      derr_cnt <= '0;
    end else if (err_clr) begin
      derr_cnt <= cnt_derr ? ERR_ONE : '0;
    end else if (cnt_derr && (derr_cnt != ERR_MAX)) begin
      derr_cnt <= derr_cnt + ERR_ONE;
    end
  end

  // First-error log: only the first error after reset/clear is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_vld  <= 1'b0;
      err_dbl  <= 1'b0;
      err_adr  <= '0;
      err_padr <= '0;
    end else if (err_evt && (~err_vld || err_clr)) begin
      err_vld  <= 1'b1;
      err_dbl  <= rd_derr;
      err_adr  <= tq_head.adr;
      err_padr <= rd_padr;
    end else if (err_clr) begin
      err_vld  <= 1'b0;
      err_dbl  <= 1'b0;
      err_adr  <= '0;
      err_padr <= '0;
    end
  end

  // Sticky protocol-violation flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      unexp <= 1'b0;
    end else if (rd_vld & tq_empty) begin
      unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_algo_1r2wg_rd_tracker.sv
// Directed bench for algo_1r2wg_rd_tracker: a 2-cycle macro model feeds returns, and a
// scoreboard of issued requests is checked against every popped response.
module tb_algo_1r2wg_rd_tracker;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        req_vld;
  logic        req_rdy;
  logic [12:0] req_adr;
  logic [3:0]  req_tag;
  logic        read;
  logic [12:0] rd_adr;
  logic        rd_vld;
  logic [31:0] rd_dout;
  logic        rd_serr;
  logic        rd_derr;
  logic [14:0] rd_padr;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_dout;
  logic        rsp_serr;
  logic        rsp_derr;
  logic        err_clr;
  logic [3:0]  serr_cnt;
  logic [3:0]  derr_cnt;
  logic        err_vld;
  logic        err_dbl;
  logic [12:0] err_adr;
  logic [14:0] err_padr;
  logic        unexp;

  algo_1r2wg_rd_tracker #(
    .WIDTH(32), .BITADDR(13), .BITPADR(15), .BITTAG(4),
    .DEPTH(8), .BITDPTH(3), .CNTWDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_adr(req_adr), .req_tag(req_tag),
    .read(read), .rd_adr(rd_adr),
    .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_serr(rd_serr), .rd_derr(rd_derr), .rd_padr(rd_padr),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_tag(rsp_tag), .rsp_dout(rsp_dout),
    .rsp_serr(rsp_serr), .rsp_derr(rsp_derr),
    .err_clr(err_clr), .serr_cnt(serr_cnt), .derr_cnt(derr_cnt),
    .err_vld(err_vld), .err_dbl(err_dbl), .err_adr(err_adr), .err_padr(err_padr),
    .unexp(unexp)
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] dout;
    logic        serr;
    logic        derr;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   m_crd = DEPTH;
  int   m_tcnt = 0;
  int   m_rcnt = 0;
  int   n_read_obs = 0;
  int   t_first_iss = -1;
  int   t_first_rsp = -1;
  bit   serr_map [256];
  bit   derr_map [256];
  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic [12:0] pa0 = '0, pa1 = '0;
  logic        clr_armed = 1'b0;
  logic [12:0] clr_adr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // One clock: check comb/registered outputs, update the model, advance the macro pipe.
  task automatic tick();
    logic iss, pop, mat, rst_s;
    exp_t e;
    #1;
    rst_s = rst;
    iss = req_vld && ready && (m_crd != 0) && !rst_s;
    pop = rsp_rdy && (m_rcnt != 0) && !rst_s;
    mat = rd_vld && (m_tcnt != 0) && !rst_s;
    if (!rst_s) begin
      chk("req_rdy", req_rdy, ready && (m_crd != 0));
      chk("read", read, iss);
      chk("rsp_vld", rsp_vld, m_rcnt != 0);
      if (read === 1'b1) n_read_obs++;
      if (iss) chk("rd_adr", rd_adr, req_adr);
      if (iss && t_first_iss < 0) t_first_iss = cyc;
      if (m_rcnt != 0 && t_first_rsp < 0) t_first_rsp = cyc;
    end
    if (pop) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 64'(sbq.size()), 1);
      end else begin
        e = sbq.pop_front();
        chk("rsp_tag", rsp_tag, e.tag);
        chk("rsp_dout", rsp_dout, e.dout);
        chk("rsp_serr", rsp_serr, e.serr);
        chk("rsp_derr", rsp_derr, e.derr);
      end
    end
    if (iss) begin
      e.tag  = req_tag;
      e.dout = 32'hA0 + 32'(req_adr);
      e.serr = serr_map[req_adr[7:0]];
      e.derr = derr_map[req_adr[7:0]];
      sbq.push_back(e);
    end
    if (rst_s) begin
      m_crd = DEPTH; m_tcnt = 0; m_rcnt = 0;
      sbq.delete();
    end else begin
      m_crd  = m_crd + int'(pop) - int'(iss);
      m_tcnt = m_tcnt + int'(iss) - int'(mat);
      m_rcnt = m_rcnt + int'(mat) - int'(pop);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rst_s) begin
      pv0 = 1'b0; pv1 = 1'b0;
    end else begin
      pv1 = pv0; pa1 = pa0;
      pv0 = iss; pa0 = req_adr;
    end
    rd_vld  = pv1;
    rd_dout = 32'hA0 + 32'(pa1);
    rd_serr = pv1 & serr_map[pa1[7:0]];
    rd_derr = pv1 & derr_map[pa1[7:0]];
    rd_padr = 15'(pa1) + 15'h0F0;
    err_clr = 1'b0;
    if (clr_armed && pv1 && (pa1 == clr_adr)) begin
      err_clr   = 1'b1;
      clr_armed = 1'b0;
    end
  endtask

  task automatic drain();
    int g = 0;
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    while ((m_tcnt != 0 || m_rcnt != 0) && g < 100) begin
      tick();
      g++;
    end
    chk("drain_budget", 64'(g >= 100), 0);
  endtask

  task automatic issue(input logic [12:0] adr, input logic [3:0] tag);
    req_vld = 1'b1;
    req_adr = adr;
    req_tag = tag;
    tick();
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; req_vld = 1'b0; req_adr = '0; req_tag = '0;
    rd_vld = 1'b0; rd_dout = '0; rd_serr = 1'b0; rd_derr = 1'b0; rd_padr = '0;
    rsp_rdy = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    #1;
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_dout", rsp_dout, 0);
    chk("rst_serr_cnt", serr_cnt, 0);
    chk("rst_derr_cnt", derr_cnt, 0);
    chk("rst_err_vld", err_vld, 0);
    chk("rst_err_adr", err_adr, 0);
    chk("rst_unexp", unexp, 0);

    // Back-to-back issue, tags 0..7, data 0xA0+i.
    rsp_rdy = 1'b1;
    t_first_iss = -1; t_first_rsp = -1;
    for (int i = 0; i < 8; i++) begin
      req_vld = 1'b1; req_adr = 13'(i); req_tag = 4'(i);
      #1 chk("b2b_req_rdy", req_rdy, 1);
      tick();
    end
    drain();
    chk("b2b_latency", 64'(t_first_rsp - t_first_iss), 3);

    // Credit exhaustion with the host stalled.
    rsp_rdy = 1'b0;
    for (int i = 0; i < 8; i++) issue(13'h30 + 13'(i), 4'(i));
    req_adr = 13'h38; req_tag = 4'h8;
    #1 chk("crd_exhaust_req_rdy", req_rdy, 0);
    repeat (4) tick();
    chk("crd_still_zero", req_rdy, 0);
    n_read_obs = 0;
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    repeat (4) tick();
    chk("crd_one_more", 64'(n_read_obs), 1);
    drain();

    // Ready drop: no new issue, outstanding reads still drain.
    issue(13'h3A, 4'hA);
    issue(13'h3B, 4'hB);
    ready = 1'b0;
    req_adr = 13'h3C;
    repeat (4) begin
      req_vld = 1'b1;
      #1 chk("ready_low_read", read, 0);
      tick();
    end
    drain();
    ready = 1'b1;

    // Error accounting: serr, serr, derr, serr+derr.
    serr_map[8'h10] = 1'b1; serr_map[8'h11] = 1'b1;
    derr_map[8'h12] = 1'b1;
    serr_map[8'h13] = 1'b1; derr_map[8'h13] = 1'b1;
    for (int i = 0; i < 4; i++) issue(13'h10 + 13'(i), 4'(i + 3));
    drain();
    chk("acc_serr_cnt", serr_cnt, 2);
    chk("acc_derr_cnt", derr_cnt, 2);
    chk("acc_err_vld", err_vld, 1);
    chk("acc_err_dbl", err_dbl, 0);
    chk("acc_err_adr", err_adr, 13'h10);
    chk("acc_err_padr", err_padr, 15'h100);

    // Clear colliding with a derr return: the error wins.
    derr_map[8'h20] = 1'b1;
    clr_armed = 1'b1; clr_adr = 13'h20;
    issue(13'h20, 4'hC);
    drain();
    chk("clr_fired", clr_armed, 0);
    chk("clr_serr_cnt", serr_cnt, 0);
    chk("clr_derr_cnt", derr_cnt, 1);
    chk("clr_err_vld", err_vld, 1);
    chk("clr_err_dbl", err_dbl, 1);
    chk("clr_err_adr", err_adr, 13'h20);
    chk("clr_err_padr", err_padr, 15'h110);

    // Saturation at 15 with a 4-bit counter.
    for (int i = 0; i < 22; i++) serr_map[8'h40 + 8'(i)] = 1'b1;
    for (int i = 0; i < 20; i++) issue(13'h40 + 13'(i), 4'(i));
    drain();
    chk("sat_serr_cnt", serr_cnt, 15);
    issue(13'h54, 4'h1);
    issue(13'h55, 4'h2);
    drain();
    chk("sat_hold", serr_cnt, 15);
    chk("sat_derr_cnt", derr_cnt, 1);
    chk("sat_err_adr", err_adr, 13'h20);

    // Unexpected return: flag only, no response and no counting.
    rd_vld = 1'b1; rd_derr = 1'b1;
    tick();
    tick();
    chk("unexp_set", unexp, 1);
    chk("unexp_rsp_vld", rsp_vld, 0);
    chk("unexp_derr_cnt", derr_cnt, 1);
    err_clr = 1'b1;
    tick();
    chk("unexp_after_clr", unexp, 1);
    chk("clr_only_serr", serr_cnt, 0);
    chk("clr_only_err_vld", err_vld, 0);

    // Reset with three reads outstanding.
    rsp_rdy = 1'b0;
    issue(13'h60, 4'h1);
    issue(13'h61, 4'h2);
    issue(13'h62, 4'h3);
    req_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_rsp_vld", rsp_vld, 0);
    chk("rst2_req_rdy", req_rdy, ready);
    chk("rst2_unexp", unexp, 0);
    chk("rst2_derr_cnt", derr_cnt, 0);

    // After reset the pairing restarts cleanly.
    rsp_rdy = 1'b1;
    issue(13'h07, 4'h5);
    drain();
    chk("post_rst_unexp", unexp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
